// File: rtl/multicycle_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: opcodes, ALU operation
// codes, FSM state encoding and small opcode-decode helpers.
package multicycle_pkg;

    // Opcodes recognised by the controller
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALU operation codes, unchanged from the single-cycle decoder
    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_BEQ   = 3'b001;
    localparam logic [2:0] ALU_BNE   = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;

    // FSM state encoding, visible on state_o
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_FETCH  = 3'b001;
    localparam logic [2:0] ST_DECODE = 3'b010;
    localparam logic [2:0] ST_EXEC   = 3'b011;
    localparam logic [2:0] ST_MEM    = 3'b100;
    localparam logic [2:0] ST_WB     = 3'b101;
    localparam logic [2:0] ST_TRAP   = 3'b111;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_ORI) || (op == OP_LUI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        logic [2:0] code;
        case (op)
            OP_BEQ:                   code = ALU_BEQ;
            OP_BNE:                   code = ALU_BNE;
            OP_ADDI, OP_LW, OP_SW:    code = ALU_ADD;
            OP_LUI:                   code = ALU_LUI;
            OP_ORI:                   code = ALU_ORI;
            default:                  code = ALU_RTYPE;
        endcase
        return code;
    endfunction

    // Immediate operand for every I-type arithmetic and memory instruction
    function automatic logic alu_src_of(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: cleared on request, counts un-acknowledged cycles, saturates
// at all-ones and flags expiry when it reaches MEM_TIMEOUT (0 disables expiry).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);
    localparam logic [TMR_W-1:0] SAT   = '1;

    logic [TMR_W-1:0] count_reg;

    // Saturating wait-cycle count; clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != SAT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (count_reg == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU. Sequences the shared memory port,
// IR, PC, ALU and register file through IDLE/FETCH/DECODE/EXEC/MEM/WB.
// Optional feature: define MULTICYCLE_ILLEGAL_TRAP_EN to trap on illegal opcodes
// (adds trap_o and the TRAP state); otherwise illegal opcodes behave as a NOP.
// MEM_TIMEOUT must be smaller than 2**TMR_W.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic [2:0] ALU_op_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       mem_to_reg_o,
    output logic       timeout_o,
    output logic [2:0] state_o
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,
    output logic       trap_o
`endif
);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    localparam logic [2:0] ILLEGAL_NEXT = ST_TRAP;
`else
    localparam logic [2:0] ILLEGAL_NEXT = ST_FETCH;
`endif

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic [5:0] op_reg;
    logic       wait_state;
    logic       tmr_expired;
    logic       abandon;

    // A request is abandoned only when the timer has expired and no ack arrives
    // in that same cycle; the pulse is asserted in the abandoning cycle itself.
    assign wait_state = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign abandon    = wait_state && tmr_expired && !mem_ack_i;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (!wait_state || mem_ack_i || abandon),
        .enable  (wait_state && !mem_ack_i),
        .expired (tmr_expired)
    );

    // State register and opcode latch (opcode captured on leaving DECODE)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE) begin
                op_reg <= instr_op_i;
            end
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack_i)    state_next = ST_DECODE;
                else if (abandon) state_next = ST_FETCH;
            end
            ST_DECODE: state_next = op_legal(instr_op_i) ? ST_EXEC : ILLEGAL_NEXT;
            ST_EXEC: begin
                if ((op_reg == OP_BEQ) || (op_reg == OP_BNE))    state_next = ST_FETCH;
                else if ((op_reg == OP_LW) || (op_reg == OP_SW)) state_next = ST_MEM;
                else                                             state_next = ST_WB;
            end
            ST_MEM: begin
                if (mem_ack_i)    state_next = (op_reg == OP_SW) ? ST_FETCH : ST_WB;
                else if (abandon) state_next = ST_FETCH;
            end
            ST_WB:     state_next = ST_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            ST_TRAP:   state_next = ST_TRAP;
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode from state and latched opcode; IR/PC writes follow the fetch ack
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        ALU_op_o     = ALU_RTYPE;
        ALUSrc_o     = 1'b0;
        RegWrite_o   = 1'b0;
        RegDst_o     = 1'b0;
        mem_to_reg_o = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req_o  = 1'b1;
                ir_write_o = mem_ack_i;
                pc_write_o = mem_ack_i;
            end
            ST_EXEC: begin
                ALU_op_o = alu_op_of(op_reg);
                ALUSrc_o = alu_src_of(op_reg);
                branch_o = (op_reg == OP_BEQ) || (op_reg == OP_BNE);
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = (op_reg == OP_SW);
                ALU_op_o  = alu_op_of(op_reg);
                ALUSrc_o  = alu_src_of(op_reg);
            end
            ST_WB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = (op_reg == OP_RTYPE);
                mem_to_reg_o = (op_reg == OP_LW);
                ALU_op_o     = alu_op_of(op_reg);
                ALUSrc_o     = alu_src_of(op_reg);
            end
            default: ;
        endcase
    end

    assign timeout_o = abandon;
    assign state_o   = state_reg;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign trap_o    = (state_reg == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Each instruction is planned as a list of expected
// cycles built from per-phase rules (fetch attempts, decode, execute, memory attempts,
// writeback), then driven and compared cycle by cycle.
module tb_multicycle_ctrl;

    localparam int TMO = 15;

    localparam logic [5:0] R_OP  = 6'd0;
    localparam logic [5:0] BEQ   = 6'd4;
    localparam logic [5:0] BNE   = 6'd5;
    localparam logic [5:0] ADDI  = 6'd8;
    localparam logic [5:0] ORI   = 6'd13;
    localparam logic [5:0] LUI   = 6'd15;
    localparam logic [5:0] LW    = 6'd35;
    localparam logic [5:0] SW    = 6'd43;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ack;
    logic [5:0] instr_op;
    logic       mem_req, mem_we, iord, ir_write, pc_write, branch;
    logic [2:0] alu_op;
    logic       alu_src, reg_write, reg_dst, mem_to_reg, timeout;
    logic [2:0] state;
    logic       trap_act;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TMR_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_op_i   (instr_op),
        .mem_ack_i    (mem_ack),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .iord_o       (iord),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .branch_o     (branch),
        .ALU_op_o     (alu_op),
        .ALUSrc_o     (alu_src),
        .RegWrite_o   (reg_write),
        .RegDst_o     (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .timeout_o    (timeout),
        .state_o      (state)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,
        .trap_o       (trap_act)
`endif
    );

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    assign trap_act = 1'b0;
`endif

    typedef struct {
        logic       ack;
        logic [5:0] op;
        logic [2:0] st;
        logic       req, we, iord, irw, pcw, br;
        logic [2:0] alu;
        logic       src, regw, regdst, m2r, tmo, trap;
    } exp_t;

    exp_t plan[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {R_OP, BEQ, BNE, ADDI, ORI, LUI, LW, SW};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        if (op == BEQ) return 3'b001;
        if (op == BNE) return 3'b010;
        if (op inside {ADDI, LW, SW}) return 3'b011;
        if (op == LUI) return 3'b100;
        if (op == ORI) return 3'b101;
        return 3'b000;
    endfunction

    // Every field zero except state; ack and opcode inputs are random noise
    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e.ack = 1'($urandom); e.op = 6'($urandom); e.st = st;
        e.req = 0; e.we = 0; e.iord = 0; e.irw = 0; e.pcw = 0; e.br = 0; e.alu = 0;
        e.src = 0; e.regw = 0; e.regdst = 0; e.m2r = 0; e.tmo = 0; e.trap = 0;
        return e;
    endfunction

    // One abandoned request: TMO silent cycles, then the cycle that gives up
    task automatic push_abandon(input exp_t t);
        exp_t e = t;
        e.ack = 1'b0;
        for (int i = 0; i < TMO; i++) plan.push_back(e);
        e.tmo = 1'b1;
        plan.push_back(e);
    endtask

    // Plan one instruction: ff failed fetch attempts, fetch ack after kf idle cycles,
    // memory phase either abandoned (mt) or acked after km idle cycles
    task automatic plan_instr(input logic [5:0] op, input int ff, input int kf,
                              input bit mt, input int km);
        exp_t t;
        bit   is_mem;
        t = blank(S_FETCH); t.req = 1'b1;
        for (int f = 0; f < ff; f++) push_abandon(t);
        t.ack = 1'b0;
        for (int i = 0; i < kf; i++) plan.push_back(t);
        t.ack = 1'b1; t.irw = 1'b1; t.pcw = 1'b1;
        plan.push_back(t);
        t = blank(S_DEC); t.op = op;
        plan.push_back(t);
        if (!is_legal(op)) return;
        t = blank(S_EXEC); t.alu = alu_of(op);
        t.src = op inside {ADDI, ORI, LUI, LW, SW};
        t.br  = (op == BEQ) || (op == BNE);
        plan.push_back(t);
        if (t.br) return;
        is_mem = (op == LW) || (op == SW);
        if (is_mem) begin
            t = blank(S_MEM); t.req = 1'b1; t.iord = 1'b1; t.we = (op == SW);
            t.alu = alu_of(op); t.src = 1'b1;
            if (mt) begin
                push_abandon(t);
                return;
            end
            t.ack = 1'b0;
            for (int i = 0; i < km; i++) plan.push_back(t);
            t.ack = 1'b1;
            plan.push_back(t);
            if (op == SW) return;
        end
        t = blank(S_WB); t.regw = 1'b1; t.regdst = (op == R_OP); t.m2r = (op == LW);
        t.alu = alu_of(op); t.src = op inside {ADDI, ORI, LUI, LW, SW};
        plan.push_back(t);
    endtask

    function automatic logic [17:0] act_vec();
        return {state, mem_req, mem_we, iord, ir_write, pc_write, branch, alu_op,
                alu_src, reg_write, reg_dst, mem_to_reg, timeout, trap_act};
    endfunction

    task automatic compare(input string tag, input logic [17:0] want);
        logic [17:0] got;
        got = act_vec();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%05h want=%05h", tag, cyc, got, want);
        end
    endtask

    task automatic apply(input exp_t e);
        @(negedge clk);
        mem_ack  = e.ack;
        instr_op = e.op;
        #2;
        cyc++;
        compare("cycle", {e.st, e.req, e.we, e.iord, e.irw, e.pcw, e.br, e.alu,
                          e.src, e.regw, e.regdst, e.m2r, e.tmo, e.trap});
    endtask

    task automatic run_plan(input int max_n, input string name);
        int n = 0;
        while (plan.size() > 0 && n < max_n) begin
            apply(plan.pop_front());
            n++;
        end
        $display("%s: %0d cycles", name, n);
    endtask

    task automatic pin(input string tag, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Async reset away from any edge, outputs must drop at once; release, then one IDLE cycle
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 compare("reset_async", 18'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        plan.delete();
        plan.push_back(blank(S_IDLE));
        run_plan(1, "idle");
    endtask

    function automatic logic [5:0] pick_op(input bit allow_illegal);
        logic [5:0] legal_ops [8];
        logic [5:0] op;
        int         r;
        legal_ops = '{R_OP, BEQ, BNE, ADDI, ORI, LUI, LW, SW};
        r = $urandom_range(0, 9);
        if (r == 8 && allow_illegal) begin
            do op = 6'($urandom); while (is_legal(op));
            return op;
        end
        return legal_ops[$urandom_range(0, 7)];
    endfunction

    function automatic int pick_wait();
        int r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 2);
        if (r < 8) return TMO;
        return $urandom_range(0, TMO);
    endfunction

    initial begin
        rst = 1'b1; mem_ack = 1'b0; instr_op = 6'd0;
        repeat (2) @(posedge clk);
        do_reset();

        // Model pins: single-cycle acks give the expected per-class latencies
        plan_instr(R_OP, 0, 0, 0, 0); pin("len_rtype", plan.size(), 4); run_plan(100, "rtype");
        plan_instr(LW, 0, 0, 0, 3);   pin("len_lw_wait3", plan.size(), 8);
        pin("lw_wb_m2r", int'(plan[plan.size()-1].m2r), 1);
        run_plan(100, "lw_wait3");
        plan_instr(SW, 0, 0, 0, 0);   pin("len_sw", plan.size(), 4);
        pin("sw_mem_we", int'(plan[3].we), 1);
        run_plan(100, "sw");
        plan_instr(BEQ, 0, 0, 0, 0);  pin("len_beq", plan.size(), 3);
        pin("beq_alu", int'(plan[2].alu), 1);
        run_plan(100, "beq");
        plan_instr(LW, 0, 0, 0, 0);   pin("len_lw", plan.size(), 5); run_plan(100, "lw");
        plan_instr(R_OP, 1, TMO, 0, 0); pin("len_fetch_tmo", plan.size(), 35);
        run_plan(100, "fetch_timeout_then_ack_at_limit");
        plan_instr(SW, 0, 0, 1, 0);   pin("len_mem_tmo", plan.size(), 19);
        run_plan(100, "mem_timeout");

        // Reset while waiting in MEM
        plan_instr(LW, 0, 0, 0, 8);
        run_plan(6, "lw_until_mem");
        do_reset();

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        plan_instr(6'h3F, 0, 0, 0, 0); pin("len_illegal", plan.size(), 2);
        run_plan(100, "illegal_nop");
`endif

        for (int i = 0; i < 400; i++) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            plan_instr(pick_op(1'b0), ($urandom_range(0, 19) == 0) ? 1 : 0, pick_wait(),
                       $urandom_range(0, 14) == 0, pick_wait());
`else
            plan_instr(pick_op(1'b1), ($urandom_range(0, 19) == 0) ? 1 : 0, pick_wait(),
                       $urandom_range(0, 14) == 0, pick_wait());
`endif
            run_plan(200, "rand");
        end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        begin
            exp_t t;
            plan_instr(6'h3F, 0, 0, 0, 0);
            for (int i = 0; i < 5; i++) begin
                t = blank(S_TRAP); t.trap = 1'b1;
                plan.push_back(t);
            end
            run_plan(100, "illegal_trap");
            do_reset();
            plan_instr(ADDI, 0, 1, 0, 0);
            run_plan(100, "after_trap");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
